// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one RAM between the CPU (port 0) and a
// second bus master (port 1), with a bounded burst while the other port waits.
module mem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ready0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ready1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          last_grant_q, last_grant_d;

    // On a tie the port that did not hold the bus last wins.
    function automatic state_t pick(input logic r0, input logic r1, input logic lg);
        if (r0 && r1) return lg ? OWN0 : OWN1;
        if (r0)       return OWN0;
        if (r1)       return OWN1;
        return IDLE;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: state_d = pick(req0, req1, last_grant_q);
            OWN0: begin
                if (req0) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        if (req1) state_d = OWN1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + ONE;
                    end
                end else begin
                    last_grant_d = 1'b0;
                    state_d      = pick(1'b0, req1, 1'b0);
                end
            end
            OWN1: begin
                if (req1) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        if (req0) state_d = OWN0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + ONE;
                    end
                end else begin
                    last_grant_d = 1'b1;
                    state_d      = pick(req0, 1'b0, 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Any change of owner starts a fresh tenure and records the new grant.
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == OWN0) last_grant_d = 1'b0;
            if (state_d == OWN1) last_grant_d = 1'b1;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        owner     = state_q;
        case (state_q)
            OWN0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_we    = rw0 & req0;
                ready0    = req0;
                rdata0    = mem_rdata;
            end
            OWN1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_we    = rw1 & req1;
                ready1    = req1;
                rdata1    = mem_rdata;
            end
            default: owner = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner
// sequences and randomized traffic against a tenure-level reference model.
module tb_mem_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, rw0, req1, rw1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ready0, ready1, mem_we;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] owner;
    logic [7:0] ram [256];

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the bus, how many accesses served this tenure,
    // and which port was granted last.
    int m_own;
    int m_run;
    int m_last;

    mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .ready0(ready0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .ready1(ready1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    typedef struct {
        logic       req0, rw0;
        logic [7:0] addr0, wdata0;
        logic       req1, rw1;
        logic [7:0] addr1, wdata1;
        logic [1:0] e_owner;
        logic       e_r0, e_r1, e_we;
        logic [7:0] e_addr, e_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 1'b0; rw0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; rw1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_own = 0; m_run = 0; m_last = 1;
    endtask

    function automatic int pick_port(input logic r0, input logic r1, input int last);
        if (r0 && r1) return (last == 1) ? 1 : 2;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    task automatic model_check();
        logic [1:0] eo;
        logic       er0, er1, ewe;
        logic [7:0] ea, ewd, erd0, erd1;
        eo = 2'(m_own);
        er0 = 1'b0; er1 = 1'b0; ewe = 1'b0; ea = 8'h00; ewd = 8'h00; erd0 = 8'h00; erd1 = 8'h00;
        if (m_own == 1) begin
            ea = addr0; ewd = wdata0; ewe = rw0 & req0; er0 = req0; erd0 = ram[addr0];
        end else if (m_own == 2) begin
            ea = addr1; ewd = wdata1; ewe = rw1 & req1; er1 = req1; erd1 = ram[addr1];
        end
        chk("rnd_owner", owner, eo);
        chk("rnd_ready0", ready0, er0);
        chk("rnd_ready1", ready1, er1);
        chk("rnd_we", mem_we, ewe);
        chk("rnd_addr", mem_addr, ea);
        chk("rnd_wdata", mem_wdata, ewd);
        chk("rnd_rdata0", rdata0, erd0);
        chk("rnd_rdata1", rdata1, erd1);
    endtask

    task automatic model_step();
        logic mine, other;
        int   nxt;
        if (m_own == 0) begin
            nxt = pick_port(req0, req1, m_last);
            if (nxt != 0) begin m_own = nxt; m_run = 0; m_last = nxt - 1; end
        end else begin
            mine  = (m_own == 1) ? req0 : req1;
            other = (m_own == 1) ? req1 : req0;
            if (!mine) begin
                m_last = m_own - 1;
                m_run  = 0;
                m_own  = pick_port(req0, req1, m_last);
                if (m_own != 0) m_last = m_own - 1;
            end else if (other && m_run >= MAXB - 1) begin
                m_own  = 3 - m_own;
                m_last = m_own - 1;
                m_run  = 0;
            end else if (m_run < MAXB - 1) begin
                m_run = m_run + 1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'hF0] = 8'hA5;

        tbl[0] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 2'b00,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[1] = '{1'b1,1'b0,8'hF0,8'h00, 1'b0,1'b0,8'h00,8'h00, 2'b00,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[2] = '{1'b1,1'b0,8'hF0,8'h00, 1'b0,1'b0,8'h00,8'h00, 2'b01,1'b1,1'b0,1'b0,8'hF0,8'hA5};
        tbl[3] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h10,8'h3C, 2'b01,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[4] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h10,8'h3C, 2'b10,1'b0,1'b1,1'b1,8'h10,8'h00};
        tbl[5] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b1,8'h00,8'h3C, 2'b10,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[6] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 2'b01,1'b1,1'b0,1'b0,8'h10,8'h3C};
        tbl[7] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 2'b01,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[8] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 2'b00,1'b0,1'b0,1'b0,8'h00,8'h00};

        rst = 1'b0;
        clear_inputs();
        #2;
        chk("rst_owner", owner, 2'b00);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_ready", {ready0, ready1}, 2'b00);
        chk("rst_rdata", {rdata0, rdata1}, 16'h0000);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            req0 = tbl[i].req0; rw0 = tbl[i].rw0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
            req1 = tbl[i].req1; rw1 = tbl[i].rw1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
            @(negedge clk);
            chk($sformatf("vec%0d_owner", i), owner, tbl[i].e_owner);
            chk($sformatf("vec%0d_ready0", i), ready0, tbl[i].e_r0);
            chk($sformatf("vec%0d_ready1", i), ready1, tbl[i].e_r1);
            chk($sformatf("vec%0d_we", i), mem_we, tbl[i].e_we);
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_r0) chk($sformatf("vec%0d_rdata0", i), rdata0, tbl[i].e_rd);
            if (tbl[i].e_r1) chk($sformatf("vec%0d_rdata1", i), rdata1, tbl[i].e_rd);
            tick();
        end

        // Reset asserted in the middle of a port 1 write.
        do_reset();
        ram[8'h20] = 8'h00;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h77;
        tick();
        @(negedge clk);
        chk("midwr_we_before", mem_we, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midwr_we_after", mem_we, 1'b0);
        chk("midwr_owner", owner, 2'b00);
        chk("midwr_ready1", ready1, 1'b0);
        chk("midwr_addr", mem_addr, 8'h00);
        tick();
        chk("midwr_no_write", ram[8'h20], 8'h00);

        // Simultaneous requests held: alternating bursts of MAXB, no idle gap.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h01; addr1 = 8'h02;
        @(negedge clk);
        chk("both_idle", owner, 2'b00);
        tick();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("both_owner_c%0d", k), owner, (((k - 1) / MAXB) % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("both_ready_c%0d", k), {ready1, ready0},
                (((k - 1) / MAXB) % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end

        // Port 1 drops while port 0 waits, then re-requests and must be served soon.
        do_reset();
        req1 = 1'b1;
        tick();
        req0 = 1'b1; req1 = 1'b0;
        tick();
        @(negedge clk);
        chk("drop_owner", owner, 2'b01);
        req1 = 1'b1;
        begin
            int waited;
            waited = 0;
            for (int n = 1; n <= 5; n++) begin
                tick();
                @(negedge clk);
                if (ready1 && waited == 0) waited = n;
            end
            chk("rearm_served_in_5", (waited != 0), 1'b1);
        end

        // Port 0 alone for 20 cycles: no forced release, counter saturated.
        do_reset();
        req0 = 1'b1; addr0 = 8'h05;
        tick();
        begin
            int streak;
            streak = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ready0 && owner == 2'b01) streak++;
                tick();
            end
            chk("solo_ready_cycles", streak, 20);
        end
        req1 = 1'b1;
        @(negedge clk);
        chk("solo_still_owner", owner, 2'b01);
        tick();
        @(negedge clk);
        chk("solo_sat_switch", owner, 2'b10);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            rw0 = $urandom_range(0, 1); rw1 = $urandom_range(0, 1);
            addr0 = 8'($urandom_range(0, 15)); addr1 = 8'($urandom_range(0, 15));
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            @(negedge clk);
            model_check();
            model_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 8x256 RAM between the be8 CPU (port 0) and a second bus master (port 1), such as a program loader or DMA engine.
- Sits between the masters and the RAM. It drives the RAM address, write enable and write data, returns read data, and drives each master's ready line.
- Round-robin arbitration with a bounded burst length, so neither master can starve the other.

Parameters:
AW, 8, address width
DW, 8, data width
MAX_BURST, 4, max consecutive accesses one owner may take while the other port is requesting (must be >=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = in reset)
req0  input  1  port 0 access request
rw0  input  1  port 0 direction: 1=write, 0=read
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
ready0  output  1  port 0 access completes this cycle
rdata0  output  DW  port 0 read data, valid when ready0=1
req1, rw1, addr1, wdata1, ready1, rdata1  same as port 0, for port 1
mem_addr  output  AW  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  DW  RAM write data (external tristate adapter drives RAM d when mem_we=1)
mem_rdata  input  DW  RAM read data
owner  output  2  00=idle, 01=port0, 10=port1 (debug/observability)

Behaviour:
- Reset (rst=0, async, takes effect immediately):
  - state=IDLE, burst_cnt=0, last_grant=1 (port 0 wins the first tie).
  - Outputs: ready0=ready1=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=00, rdata0=rdata1=0.
  - Reset mid-access aborts the access; no write occurs after rst falls.
- FSM states: IDLE, OWN0, OWN1; state, burst_cnt and last_grant are registered.
- Combinational outputs:
  - In OWNx: mem_addr=addrx; mem_wdata=wdatax; mem_we=rwx & reqx; readyx=reqx; ready of the other port=0.
  - In IDLE: mem_we=0, mem_addr=0, mem_wdata=0, ready0=ready1=0.
  - rdata0=mem_rdata when state=OWN0, else 0; rdata1 likewise for OWN1.
- One access completes per clock while owned: every cycle with state=OWNx and reqx=1 is one completed access.
- Arbitration function pick(r0,r1):
  - Only one requesting: that port.
  - Both requesting: port != last_grant.
  - Neither requesting: IDLE.
- IDLE -> pick(req0,req1); entering OWNx sets burst_cnt=0 and last_grant=x. Latency from req rising to ready: exactly 1 clock.
- OWNx, reqx=1, other not requesting: stay; burst_cnt saturates at MAX_BURST-1 (no forced release when uncontended).
- OWNx, reqx=1, other requesting:
  - burst_cnt < MAX_BURST-1: stay, burst_cnt+1.
  - burst_cnt == MAX_BURST-1: switch directly to OWN(other), burst_cnt=0, last_grant=other. No idle cycle between owners.
- OWNx, reqx=0 (master done or aborted): go to pick(req0,req1) with last_grant=x, so the other port wins a tie; burst_cnt=0.
- Worst-case wait for a requesting port: MAX_BURST+1 clocks.
- Master protocol:
  - Hold req, rw, addr and wdata stable until ready is sampled 1.
  - Dropping req before ready is a legal abort with no RAM side effect, because mem_we is gated by req.
  - Changing rw or addr while owned is allowed; each cycle is an independent access.
- Simultaneous first requests after reset: port 0 granted.
- owner mirrors state (IDLE=00, OWN0=01, OWN1=10); encoding 11 is never produced.

Test Plan:
- Release reset with req0=req1=0 -> owner=00, mem_we=0, ready0=ready1=0; assert rst=0 mid-write -> mem_we drops to 0 immediately.
- req0=1 read addr0=F0, RAM[F0]=A5 -> one clock later owner=01, ready0=1, rdata0=A5; ready1=0.
- req0 and req1 raised in the same cycle, both held, MAX_BURST=4 -> port 0 gets 4 consecutive ready0 cycles, then port 1 gets 4, alternating with no idle cycle between owners.
- Port 1 writes 3C to address 10 (rw1=1) while port 0 is idle -> mem_we=1 and mem_addr=10 for one cycle; a following port 0 read of address 10 returns 3C.
- req1 dropped while owned with req0 pending -> next cycle owner=01; req1 reasserted -> served within 5 clocks.
- Port 0 alone holds req for 20 cycles -> ready0=1 for all 20 cycles, no forced release, burst_cnt saturates at 3.
